// File: rtl/sbox_bytes_serial.sv
// Serial AES SubBytes stage: one shared S-box walks the block byte 0..NBYTES-1,
// one byte per cycle, then holds the result until the consumer takes it.

module canright_sbox (
  input  logic [7:0] a,
  input  logic       encrypt,
  output logic [7:0] q
);
  // Forward and inverse directions share a single GF(2^8) inverter; only the
  // affine maps on either side of it change with direction.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gmul(gmul(x, x), x);
    x7   = gmul(gmul(x3, x3), x);
    x15  = gmul(gmul(x7, x7), x);
    x31  = gmul(gmul(x15, x15), x);
    x63  = gmul(gmul(x31, x31), x);
    x127 = gmul(gmul(x63, x63), x);
    return gmul(x127, x127);
  endfunction

  logic [7:0] pre;
  logic [7:0] inv;

  always_comb begin
    pre = encrypt ? a : (rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    inv = ginv(pre);
    q   = encrypt ? (inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63)
                  : inv;
  end
endmodule

module sbox_bytes_serial #(
  parameter int NBYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  input  logic                  in_encrypt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic                  busy
);
  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [NBYTES-1:0][7:0] wreg;
  logic                   enc;
  logic [CW-1:0]          cnt;
  logic [7:0]             sb_q;

  canright_sbox u_sbox (
    .a       (wreg[cnt]),
    .encrypt (enc),
    .q       (sb_q)
  );

  assign out_data = wreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      wreg      <= '0;
      enc       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          wreg     <= in_data;
          enc      <= in_encrypt;
          cnt      <= '0;
          state    <= RUN;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          wreg[cnt] <= sb_q;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          // in_ready rises only after the handshake edge, so a new block can
          // never be captured in the same cycle the old one leaves.
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
